uart_tx_serializer: RTL

- Transmit stage directly downstream of the calculator.
- Consumes the calculator's result bytes (tx_data qualified by tx_en) and serialises each byte onto the UART line as 8N1, or with parity if enabled.
- Drives busy back to the calculator, which holds off the next tx_en until busy is low.
- Owns the baud timing for the transmit path.

---
 rtl/uart_tx_serializer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: takes one byte per tx_en strobe and shifts it out LSB first
// as start / 8 data / optional parity / 1-2 stop bits, with its own baud timing.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_en,
   input  logic [7:0] tx_data,
   output logic       busy,
   output logic       txd,
   output logic       tx_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int STOP_W = $clog2(STOP_BITS * CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS * CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [STOP_W-1:0] stop_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              par_bit;
   logic              baud_wrap;

   function automatic logic parity_of(input logic [7:0] d);
      return (PARITY == 1) ? ~(^d) : (^d);
   endfunction

   assign baud_wrap = (baud_cnt == BAUD_LAST);

   // Shift register and parity bit are loaded on acceptance only, so they carry no reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         txd      <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
         baud_cnt <= '0;
         stop_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_en) begin
                  shreg    <= tx_data;
                  par_bit  <= parity_of(tx_data);
                  state    <= START;
                  busy     <= 1'b1;
                  txd      <= 1'b0;
                  baud_cnt <= '0;
               end
            end
            START: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  txd      <= shreg[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  shreg    <= {1'b0, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     if (PARITY != 0) begin
                        state <= PAR;
                        txd   <= par_bit;
                     end else begin
                        state    <= STOP;
                        txd      <= 1'b1;
                        stop_cnt <= '0;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PAR: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  state    <= STOP;
                  txd      <= 1'b1;
                  stop_cnt <= '0;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               // All stop bits are timed as one span; the done pulse lands with busy falling.
               if (stop_cnt == STOP_LAST) begin
                  stop_cnt <= '0;
                  state    <= IDLE;
                  busy     <= 1'b0;
                  tx_done  <= 1'b1;
               end else begin
                  stop_cnt <= stop_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
